pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the per-stage enables (ena_pc, ena_ifid, ena_idex, ena_exma, ena_mawb) and the bubble-insert flushes of the IF/ID and ID/EX registers. It handles three cases: post-reset pipeline scrubbing, load-use hazards, and multi-cycle data-memory waits. It also flushes the pipeline on a taken branch and keeps a saturating stall counter.

Parameters:
INIT_CYCLES, 4, cycles of bubble injection after reset (1..15)
MEM_TIMEOUT, 255, wait cycles before mem_timeout is raised (1..255)
LOAD_WRN, 2'b01, wrn code marking a load (write-back from memory)

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
rs1_id  in  5  source reg 1 of instruction in ID
rs2_id  in  5  source reg 2 of instruction in ID
rs1_used  in  1  ID instruction reads rs1
rs2_used  in  1  ID instruction reads rs2
rd_ex  in  5  destination reg of instruction in EX
write_ena_ex  in  1  EX instruction writes regfile
wrn_ex  in  2  write-back source select of EX instruction
mem_req  in  1  MA instruction performs a load/store this cycle
mem_ready  in  1  data memory completes the access this cycle
branch_taken_ex  in  1  EX resolved a taken branch/jump
ena_pc, ena_ifid, ena_idex, ena_exma, ena_mawb  out  1 each  stage register enables
flush_ifid, flush_idex  out  1 each  load bubble (NOP, write_ena=0) instead of input
mem_timeout  out  1  sticky: a memory wait exceeded MEM_TIMEOUT
stall_cycles  out  16  saturating count of cycles with ena_pc=0 (post-INIT)

Behaviour:
- State register: INIT, RUN, MEM_WAIT. Counter cnt[7:0]. Enables and flushes are combinational from state and current inputs. mem_timeout and stall_cycles are registered.
- rst_n=0 at posedge: state<=INIT, cnt<=0, mem_timeout<=0, stall_cycles<=0. While rst_n=0, all enables=0 and flushes=0, overriding every state.
- INIT:
  - ena_pc=0; ena_ifid, ena_idex, ena_exma, ena_mawb=1; flush_ifid=flush_idex=1.
  - cnt increments each cycle. When cnt==INIT_CYCLES-1: state<=RUN, cnt<=0.
  - All inputs are ignored. Stall counter is not incremented.
- Definitions:
  - loaduse = (wrn_ex==LOAD_WRN) & write_ena_ex & (rd_ex!=0) & ((rs1_used & rs1_id==rd_ex) | (rs2_used & rs2_id==rd_ex)).
  - memstall = mem_req & ~mem_ready.
- RUN, priority memstall > branch > loaduse:
  - memstall: all enables=0, flushes=0. state<=MEM_WAIT, cnt<=1.
  - branch_taken_ex: all enables=1, flush_ifid=flush_idex=1. loaduse is ignored because the ID instruction is squashed.
  - loaduse: ena_pc=0, ena_ifid=0, ena_idex=1, flush_idex=1, ena_exma=1, ena_mawb=1. This is a one-cycle bubble: next cycle the load is in MA and the hazard clears naturally.
  - else: all enables=1, flushes=0.
- MEM_WAIT:
  - mem_ready=0: all enables=0. cnt increments, saturating at 255. If cnt==MEM_TIMEOUT, mem_timeout<=1 (sticky until reset). Waiting continues indefinitely.
  - mem_ready=1: evaluated exactly as a RUN cycle with memstall forced false (branch/loaduse rules apply). state<=RUN, cnt<=0.
- stall_cycles: +1 on every posedge with rst_n=1, state!=INIT and ena_pc=0. Saturates at 16'hFFFF.
- Invariant: flush_x=1 only when ena_x=1. Enables never toggle during rst_n=0.
- Reset asserted mid-MEM_WAIT or mid-INIT: next state INIT, counters cleared, mem_timeout cleared.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 -> exactly INIT_CYCLES(4) cycles with ena_pc=0, flush_ifid=flush_idex=1; 5th cycle all enables=1, flushes=0; stall_cycles=0.
- Load-use: wrn_ex=2'b01, write_ena_ex=1, rd_ex=5, rs2_id=5, rs2_used=1 for one cycle -> ena_pc=ena_ifid=0, flush_idex=1, ena_exma=ena_mawb=1; stall_cycles 0->1. Same stimulus with rd_ex=0 or rs2_used=0 -> no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then ready=1 -> all enables 0 for 3 cycles, all 1 on the ready cycle; stall_cycles +3; state back to RUN.
- Priority: memstall, branch_taken_ex and loaduse asserted together -> freeze (all enables 0), no flush. On the ready cycle with branch still high -> flush_ifid=flush_idex=1, enables 1.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout rises after the 4th wait cycle and stays 1 after ready. rst_n=0 mid-wait -> INIT, mem_timeout=0.
- Saturation: force 65540 stall cycles -> stall_cycles holds 16'hFFFF.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: post-reset scrub, load-use
// bubbles, data-memory waits and taken-branch squashes.
module pipeline_ctrl #(
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter logic [1:0]  LOAD_WRN    = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic [4:0]  rd_ex,
    input  logic        write_ena_ex,
    input  logic [1:0]  wrn_ex,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        branch_taken_ex,
    output logic        ena_pc,
    output logic        ena_ifid,
    output logic        ena_idex,
    output logic        ena_exma,
    output logic        ena_mawb,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_mem_timeout;
    logic               w_timeout_set;
    logic [STALL_W-1:0] r_stall_cycles;

    logic               w_loaduse;
    logic               w_memstall;
    // {pc, ifid, idex, exma, mawb}
    logic [4:0]         w_run_ena;
    logic [1:0]         w_run_flush;
    logic [4:0]         w_ena;
    logic [1:0]         w_flush;

    assign w_loaduse = (wrn_ex == LOAD_WRN) && write_ena_ex && (rd_ex != 5'd0) &&
                       ((rs1_used && (rs1_id == rd_ex)) || (rs2_used && (rs2_id == rd_ex)));
    assign w_memstall = mem_req && !mem_ready;

    // Enables/flushes of a normal issue cycle (memory not stalling)
    always_comb begin
        w_run_ena   = 5'b11111;
        w_run_flush = 2'b00;
        if (branch_taken_ex) begin
            w_run_flush = 2'b11;
        end else if (w_loaduse) begin
            w_run_ena   = 5'b00111;
            w_run_flush = 2'b01;
        end
    end

    // Next-state, counter and stage-control decode
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timeout_set = 1'b0;
        w_ena         = 5'b00000;
        w_flush       = 2'b00;
        case (r_state)
            ST_INIT: begin
                w_ena   = 5'b01111;
                w_flush = 2'b11;
                if (r_cnt == CNT_W'(INIT_CYCLES - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (w_memstall) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_ena   = w_run_ena;
                    w_flush = w_run_flush;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    if (r_cnt != {CNT_W{1'b1}}) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    if (r_cnt == CNT_W'(MEM_TIMEOUT)) begin
                        w_timeout_set = 1'b1;
                    end
                end else begin
                    w_ena       = w_run_ena;
                    w_flush     = w_run_flush;
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
        // Reset holds every stage frozen regardless of state
        if (!rst_n) begin
            w_ena   = 5'b00000;
            w_flush = 2'b00;
        end
    end

    assign {ena_pc, ena_ifid, ena_idex, ena_exma, ena_mawb} = w_ena;
    assign {flush_ifid, flush_idex}                        = w_flush;
    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;

    // State, counter, sticky timeout and saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_INIT;
            r_cnt          <= '0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
            if ((r_state != ST_INIT) && !w_ena[4] && (r_stall_cycles != {STALL_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + STALL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

    localparam int unsigned INIT_CYCLES = 4;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam logic [1:0]  LOAD_WRN    = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic        rs1_used, rs2_used, write_ena_ex;
    logic [1:0]  wrn_ex;
    logic        mem_req, mem_ready, branch_taken_ex;
    logic        ena_pc, ena_ifid, ena_idex, ena_exma, ena_mawb;
    logic        flush_ifid, flush_idex, mem_timeout;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .INIT_CYCLES (INIT_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .LOAD_WRN    (LOAD_WRN)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .rs1_used        (rs1_used),
        .rs2_used        (rs2_used),
        .rd_ex           (rd_ex),
        .write_ena_ex    (write_ena_ex),
        .wrn_ex          (wrn_ex),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .branch_taken_ex (branch_taken_ex),
        .ena_pc          (ena_pc),
        .ena_ifid        (ena_ifid),
        .ena_idex        (ena_idex),
        .ena_exma        (ena_exma),
        .ena_mawb        (ena_mawb),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain counters describing where the pipeline is
    int init_left = 0;   // scrub cycles still to run
    bit waiting   = 0;   // a memory access is outstanding
    int wait_n    = 0;   // wait cycles so far in the current access
    bit m_timeout = 0;
    int m_stalls  = 0;
    bit m_valid   = 0;   // model registers known (after first reset)

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model
    task automatic tick();
        logic [6:0] exp;
        logic [6:0] got;
        bit lu;
        bit stall_pc;
        @(negedge clk);
        lu = (wrn_ex == LOAD_WRN) && write_ena_ex && (rd_ex != 5'd0) &&
             ((rs1_used && (rs1_id == rd_ex)) || (rs2_used && (rs2_id == rd_ex)));
        stall_pc = 1'b0;
        // exp = {pc, ifid, idex, exma, mawb, flush_ifid, flush_idex}
        if (!rst_n) begin
            exp = 7'b0000000;
        end else if (init_left > 0) begin
            exp = 7'b0111111;
        end else if ((waiting && !mem_ready) || (!waiting && mem_req && !mem_ready)) begin
            exp = 7'b0000000;
            stall_pc = 1'b1;
        end else if (branch_taken_ex) begin
            exp = 7'b1111111;
        end else if (lu) begin
            exp = 7'b0011101;
            stall_pc = 1'b1;
        end else begin
            exp = 7'b1111100;
        end
        got = {ena_pc, ena_ifid, ena_idex, ena_exma, ena_mawb, flush_ifid, flush_idex};
        check("stage_ctrl", 32'(got), 32'(exp));
        if (m_valid) begin
            check("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
            check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        end
        // Model update at the coming rising edge
        if (!rst_n) begin
            init_left = INIT_CYCLES;
            waiting   = 0;
            wait_n    = 0;
            m_timeout = 0;
            m_stalls  = 0;
            m_valid   = 1;
        end else if (init_left > 0) begin
            init_left--;
        end else begin
            if (stall_pc && m_stalls < 65535) m_stalls++;
            if (waiting && !mem_ready) begin
                if (((wait_n > 255) ? 255 : wait_n) == MEM_TIMEOUT) m_timeout = 1;
                wait_n++;
            end else if (!waiting && mem_req && !mem_ready) begin
                waiting = 1;
                wait_n  = 1;
            end else begin
                waiting = 0;
                wait_n  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; rs1_id = 5'd0; rs2_id = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        rd_ex = 5'd0; write_ena_ex = 1'b0; wrn_ex = 2'b00;
        mem_req = 1'b0; mem_ready = 1'b0; branch_taken_ex = 1'b0;
    endtask

    task automatic reset_and_init();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (INIT_CYCLES + 1) tick();
    endtask

    task automatic set_loaduse(input logic [4:0] rd, input logic used2);
        wrn_ex = 2'b01; write_ena_ex = 1'b1; rd_ex = rd; rs2_id = 5'd5; rs2_used = used2;
    endtask

    initial begin
        idle_inputs();
        reset_and_init();

        // Load-use hazard, then the two non-hazard variants
        set_loaduse(5'd5, 1'b1); tick();
        set_loaduse(5'd0, 1'b1); tick();
        set_loaduse(5'd5, 1'b0); tick();
        idle_inputs(); tick();

        // Three-cycle memory wait then ready
        mem_req = 1'b1; mem_ready = 1'b0; repeat (3) tick();
        mem_ready = 1'b1; tick();
        idle_inputs(); tick();

        // Priority: freeze beats branch and load-use; branch flushes on ready
        set_loaduse(5'd5, 1'b1);
        branch_taken_ex = 1'b1; mem_req = 1'b1; mem_ready = 1'b0; repeat (2) tick();
        mem_ready = 1'b1; tick();
        idle_inputs(); tick();

        // Load-use resolved on the ready cycle of a wait
        mem_req = 1'b1; mem_ready = 1'b0; tick();
        mem_ready = 1'b1; set_loaduse(5'd5, 1'b1); tick();
        idle_inputs(); tick();

        // Timeout: long wait, sticky after ready, cleared by reset mid-wait
        mem_req = 1'b1; mem_ready = 1'b0; repeat (7) tick();
        mem_ready = 1'b1; tick();
        idle_inputs(); repeat (2) tick();
        mem_req = 1'b1; mem_ready = 1'b0; repeat (3) tick();
        rst_n = 1'b0; repeat (2) tick();
        idle_inputs(); repeat (INIT_CYCLES + 2) tick();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n           = ($urandom_range(0, 199) != 0);
            rs1_id          = 5'($urandom_range(0, 3));
            rs2_id          = 5'($urandom_range(0, 3));
            rd_ex           = 5'($urandom_range(0, 3));
            rs1_used        = 1'($urandom_range(0, 1));
            rs2_used        = 1'($urandom_range(0, 1));
            write_ena_ex    = ($urandom_range(0, 3) != 0);
            wrn_ex          = 2'($urandom_range(0, 3));
            mem_req         = ($urandom_range(0, 3) == 0);
            mem_ready       = ($urandom_range(0, 2) != 0);
            branch_taken_ex = ($urandom_range(0, 4) == 0);
            tick();
        end

        // Stall counter saturation over a very long memory wait
        reset_and_init();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (65540) tick();
        check("stall_saturated", 32'(stall_cycles), 32'h0000FFFF);
        mem_ready = 1'b1; tick();
        idle_inputs(); tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
